// File: rtl/rns_pkg.sv
// Shared constants and types for the RNS {8,7,5,3} to binary converter.
// The mixed-radix weights and the dynamic range are derived from the moduli
// so the whole set stays consistent if a modulus is ever revisited.
package rns_pkg;

   // Moduli of the residue number system
   localparam int M8 = 8;
   localparam int M7 = 7;
   localparam int M5 = 5;
   localparam int M3 = 3;

   // Mixed-radix weights: products of the moduli preceding each digit
   localparam int W2 = M8;
   localparam int W3 = M8 * M7;
   localparam int W4 = M8 * M7 * M5;

   // Dynamic range and the fold point for the signed interpretation
   localparam int M_RANGE = W4 * M3;
   localparam int HALF    = M_RANGE / 2;

   // Multiplicative inverses used by the MRC digit recurrences
   // (INVa_b is the inverse of a modulo b)
   localparam int INV8_7 = 1;
   localparam int INV8_5 = 2;
   localparam int INV7_5 = 3;
   localparam int INV8_3 = 2;
   localparam int INV7_3 = 1;
   localparam int INV5_3 = 2;

   // Converter sequence: one mixed-radix digit per cycle, then the sum
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_A2   = 3'd1,
      ST_A3   = 3'd2,
      ST_A4   = 3'd3,
      ST_SUM  = 3'd4,
      ST_DONE = 3'd5
   } state_t;

endpackage

// File: rtl/rns_mrc_digit.sv
// One mixed-radix step for a single modulus: ((x - y) mod M) * INV mod M.
// Both operands are reduced mod M first because the subtrahend is usually a
// digit from a larger modulus (e.g. a1 in 0..7 against modulus 5).
module rns_mrc_digit #(
   parameter int unsigned M   = 7,
   parameter int unsigned INV = 1
) (
   input  logic [2:0] x_i,
   input  logic [2:0] y_i,
   output logic [2:0] d_o
);

   localparam logic [3:0] M_L   = 4'(M);
   localparam logic [5:0] M_W   = 6'(M);
   localparam logic [5:0] INV_W = 6'(INV);

   logic [3:0] x_r;
   logic [3:0] y_r;
   logic [3:0] diff;

   // Wrapped modular difference scaled by the inverse; result is 0..M-1
   always_comb begin
      x_r  = {1'b0, x_i} % M_L;
      y_r  = {1'b0, y_i} % M_L;
      diff = (x_r + M_L - y_r) % M_L;
      d_o  = 3'(({2'b00, diff} * INV_W) % M_W);
   end

endmodule

// File: rtl/rns2bin_mrc.sv
// RNS {mod8, mod7, mod5, mod3} to 10-bit two's-complement converter.
// Iterative mixed-radix conversion: a1 is latched on accept, a2..a4 are
// produced one per cycle, then the weighted sum is folded into [-420, 419].
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; in_ready is high only when idle, out_valid is held with stable
// n/err until out_ready is seen high on an edge.
module rns2bin_mrc
   import rns_pkg::*;
#(
   parameter int N_W      = 10,
   parameter bit CHECK_EN = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2:0]     mod8,
   input  logic [2:0]     mod7,
   input  logic [2:0]     mod5,
   input  logic [1:0]     mod3,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N_W-1:0] n,
   output logic           err
);

   state_t         state_q, state_d;
   logic [2:0]     x7_q, x7_d;
   logic [2:0]     x5_q, x5_d;
   logic [1:0]     x3_q, x3_d;
   logic [2:0]     a1_q, a1_d;
   logic [2:0]     a2_q, a2_d;
   logic [2:0]     a3_q, a3_d;
   logic [2:0]     a4_q, a4_d;
   logic           err_r_q, err_r_d;
   logic [N_W-1:0] n_q, n_d;
   logic           err_q, err_d;

   logic           range_bad;
   logic [2:0]     a2_c;
   logic [2:0]     t5_c;
   logic [2:0]     a3_c;
   logic [2:0]     t3_c;
   logic [2:0]     u3_c;
   logic [2:0]     a4_c;
   logic [N_W-1:0] x_sum;
   logic [N_W-1:0] n_fold;

   // Non-canonical residue detection; compiled out entirely when disabled
   if (CHECK_EN) begin : g_chk
      assign range_bad = (mod7 == 3'd7) || (mod5 > 3'd4) || (mod3 == 2'd3);
   end else begin : g_nochk
      assign range_bad = 1'b0;
   end

   // Digit a2 = (x7 - a1) * inv(8) mod 7
   rns_mrc_digit #(.M(M7), .INV(INV8_7)) u_a2 (
      .x_i (x7_q),
      .y_i (a1_q),
      .d_o (a2_c)
   );

   // Digit a3: strip a1 then a2 from x5, each followed by its inverse
   rns_mrc_digit #(.M(M5), .INV(INV8_5)) u_t5 (
      .x_i (x5_q),
      .y_i (a1_q),
      .d_o (t5_c)
   );

   rns_mrc_digit #(.M(M5), .INV(INV7_5)) u_a3 (
      .x_i (t5_c),
      .y_i (a2_q),
      .d_o (a3_c)
   );

   // Digit a4: strip a1, a2, a3 from x3 in turn
   rns_mrc_digit #(.M(M3), .INV(INV8_3)) u_t3 (
      .x_i ({1'b0, x3_q}),
      .y_i (a1_q),
      .d_o (t3_c)
   );

   rns_mrc_digit #(.M(M3), .INV(INV7_3)) u_u3 (
      .x_i (t3_c),
      .y_i (a2_q),
      .d_o (u3_c)
   );

   rns_mrc_digit #(.M(M3), .INV(INV5_3)) u_a4 (
      .x_i (u3_c),
      .y_i (a3_q),
      .d_o (a4_c)
   );

   // Mixed-radix reconstruction (0..839) and fold of the upper half to negatives.
   // The subtraction wraps modulo 2^N_W, which is exactly the two's-complement value.
   always_comb begin
      x_sum  = N_W'(a1_q)
             + N_W'(a2_q) * N_W'(W2)
             + N_W'(a3_q) * N_W'(W3)
             + N_W'(a4_q) * N_W'(W4);
      n_fold = (x_sum >= N_W'(HALF)) ? (x_sum - N_W'(M_RANGE)) : x_sum;
   end

   // Next-state and datapath updates for each step of the conversion
   always_comb begin
      state_d = state_q;
      x7_d    = x7_q;
      x5_d    = x5_q;
      x3_d    = x3_q;
      a1_d    = a1_q;
      a2_d    = a2_q;
      a3_d    = a3_q;
      a4_d    = a4_q;
      err_r_d = err_r_q;
      n_d     = n_q;
      err_d   = err_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               x7_d    = mod7;
               x5_d    = mod5;
               x3_d    = mod3;
               a1_d    = mod8;
               err_r_d = range_bad;
               state_d = ST_A2;
            end
         end
         ST_A2: begin
            a2_d    = a2_c;
            state_d = ST_A3;
         end
         ST_A3: begin
            a3_d    = a3_c;
            state_d = ST_A4;
         end
         ST_A4: begin
            a4_d    = a4_c;
            state_d = ST_SUM;
         end
         ST_SUM: begin
            // A bad residue word yields a defined zero rather than a bogus value
            n_d     = err_r_q ? '0 : n_fold;
            err_d   = err_r_q;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any conversion in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         x7_q    <= '0;
         x5_q    <= '0;
         x3_q    <= '0;
         a1_q    <= '0;
         a2_q    <= '0;
         a3_q    <= '0;
         a4_q    <= '0;
         err_r_q <= 1'b0;
         n_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x7_q    <= x7_d;
         x5_q    <= x5_d;
         x3_q    <= x3_d;
         a1_q    <= a1_d;
         a2_q    <= a2_d;
         a3_q    <= a3_d;
         a4_q    <= a4_d;
         err_r_q <= err_r_d;
         n_q     <= n_d;
         err_q   <= err_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign n         = n_q;
   assign err       = err_q;

endmodule
